// File: rtl/mystic_boot_loader.sv
// mystic_boot_loader: UART download framer (A5 5A, 24-bit LE length, payload, 8-bit sum) feeding the loader write port; ports: clk_i/rst_i, rx_valid_i/rx_data_i/rx_err_i in, uart_mem_dout/addr/we, disable_core_n, boot_done_o, boot_err_o out
module mystic_boot_loader #(
  parameter int ADDR_W = 18,
  parameter int MEM_DEPTH = 262144,
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_err_i,
  output logic [7:0]        uart_mem_dout,
  output logic [ADDR_W-1:0] uart_mem_addr,
  output logic              uart_mem_we,
  output logic              disable_core_n,
  output logic              boot_done_o,
  output logic              boot_err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SYNC, LEN0, LEN1, LEN2, DATA, CSUM} state_t;
  state_t state;
  logic [23:0] len, remaining, full_len;
  logic [ADDR_W-1:0] addr;
  logic [7:0] sum;
  logic [TW-1:0] idle_cnt;
  logic active, tmo;
  assign active = (state != IDLE) && (state != SYNC);
  assign tmo = active && !rx_valid_i && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign full_len = {rx_data_i, len[15:0]};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      len <= '0;
      remaining <= '0;
      addr <= '0;
      sum <= '0;
      idle_cnt <= '0;
      uart_mem_dout <= '0;
      uart_mem_addr <= '0;
      uart_mem_we <= 1'b0;
      disable_core_n <= 1'b1;
      boot_done_o <= 1'b0;
      boot_err_o <= 1'b0;
    end else begin
      uart_mem_we <= 1'b0;
      idle_cnt <= (active && !rx_valid_i) ? idle_cnt + 1'b1 : '0;
      // receiver errors and timeouts inside a frame abort it; the core stays held
      if (active && (rx_err_i || tmo)) begin
        boot_err_o <= 1'b1;
        state <= IDLE;
      end else if (rx_err_i) begin
        state <= IDLE;
      end else if (rx_valid_i) begin
        case (state)
          IDLE: state <= (rx_data_i == SYNC0) ? SYNC : IDLE;
          SYNC: begin
            if (rx_data_i == SYNC1) begin
              state <= LEN0;
              disable_core_n <= 1'b0;
              boot_done_o <= 1'b0;
              boot_err_o <= 1'b0;
              addr <= '0;
              sum <= '0;
            end else begin
              state <= (rx_data_i == SYNC0) ? SYNC : IDLE;
            end
          end
          LEN0: begin
            len[7:0] <= rx_data_i;
            state <= LEN1;
          end
          LEN1: begin
            len[15:8] <= rx_data_i;
            state <= LEN2;
          end
          LEN2: begin
            len[23:16] <= rx_data_i;
            remaining <= full_len;
            if ({8'd0, full_len} > 32'(MEM_DEPTH)) begin
              boot_err_o <= 1'b1;
              state <= IDLE;
            end else begin
              state <= (full_len == '0) ? CSUM : DATA;
            end
          end
          DATA: begin
            uart_mem_we <= 1'b1;
            uart_mem_dout <= rx_data_i;
            uart_mem_addr <= addr;
            addr <= addr + 1'b1;
            sum <= sum + rx_data_i;
            remaining <= remaining - 24'd1;
            state <= (remaining == 24'd1) ? CSUM : DATA;
          end
          CSUM: begin
            if (rx_data_i == sum) begin
              disable_core_n <= 1'b1;
              boot_done_o <= 1'b1;
            end else begin
              boot_err_o <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mystic_boot_loader.sv
// tb_mystic_boot_loader: table-driven frames plus hand sequences, write scoreboard checked every cycle
module tb_mystic_boot_loader;
  localparam int TMO = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_err = 1'b0;
  logic [7:0] dout;
  logic [17:0] addr;
  logic we, dcn, done, err;
  int total = 0;
  int passed = 0;
  logic [25:0] exp_q[$];

  typedef struct packed {
    logic [127:0] b;
    logic [7:0] n;
    logic [7:0] ds;
    logic [7:0] nw;
    logic done;
    logic err;
    logic dcn;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  mystic_boot_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_err_i(rx_err),
    .uart_mem_dout(dout), .uart_mem_addr(addr), .uart_mem_we(we),
    .disable_core_n(dcn), .boot_done_o(done), .boot_err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    logic [25:0] e;
    @(negedge clk);
    if (we) begin
      if (exp_q.size() == 0) chk("unexpected_write", {14'd0, addr, dout}, 32'hFFFFFFFF);
      else begin
        e = exp_q.pop_front();
        chk("write", {6'd0, addr, dout}, {6'd0, e});
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    rx_valid = 1'b1;
    rx_data = b;
    rx_err = e;
    tick();
    rx_valid = 1'b0;
    rx_err = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic flags(input string name, input logic d, input logic e, input logic c);
    chk({name, "_done"}, {31'd0, done}, {31'd0, d});
    chk({name, "_err"}, {31'd0, err}, {31'd0, e});
    chk({name, "_dcn"}, {31'd0, dcn}, {31'd0, c});
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input vec_t v);
    logic [127:0] bb;
    logic [7:0] by;
    bb = v.b;
    for (int i = 0; i < int'(v.n); i++) begin
      by = bb[8*(int'(v.n) - 1 - i) +: 8];
      if (i >= int'(v.ds) && i < int'(v.ds) + int'(v.nw)) exp_q.push_back({18'(i - int'(v.ds)), by});
      send(by, 1'b0);
    end
    idle(3);
  endtask

  initial begin
    tbl[0] = '{b: 128'({8'hA5, 8'h5A, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA}),
               n: 8'd10, ds: 8'd5, nw: 8'd4, done: 1'b1, err: 1'b0, dcn: 1'b1};
    tbl[1] = '{b: 128'({8'hA5, 8'h5A, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB}),
               n: 8'd10, ds: 8'd5, nw: 8'd4, done: 1'b0, err: 1'b1, dcn: 1'b0};
    tbl[2] = tbl[0];
    tbl[3] = '{b: 128'({8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}),
               n: 8'd7, ds: 8'd6, nw: 8'd0, done: 1'b1, err: 1'b0, dcn: 1'b1};
    tbl[4] = '{b: 128'({8'hA5, 8'h33}), n: 8'd2, ds: 8'd0, nw: 8'd0, done: 1'b1, err: 1'b0, dcn: 1'b1};
    tbl[5] = '{b: 128'({8'hA5, 8'h5A, 8'h01, 8'h00, 8'h04}),
               n: 8'd5, ds: 8'd5, nw: 8'd0, done: 1'b0, err: 1'b1, dcn: 1'b0};
    tbl[6] = '{b: 128'({8'hA5, 8'h5A, 8'h03, 8'h00, 8'h00, 8'hF0, 8'h20, 8'h05, 8'h15}),
               n: 8'd9, ds: 8'd5, nw: 8'd3, done: 1'b1, err: 1'b0, dcn: 1'b1};
    idle(3);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_addr", {14'd0, addr}, 0);
    chk("rst_dout", {24'd0, dout}, 0);
    flags("rst", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    idle(2);
    for (int k = 0; k < 7; k++) begin
      run_frame(tbl[k]);
      flags($sformatf("vec%0d", k), tbl[k].done, tbl[k].err, tbl[k].dcn);
    end
    // reset mid-DATA: two writes land, nothing after
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    chk("hold_dcn", {31'd0, dcn}, 0);
    send(8'h04, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    exp_q.push_back({18'd0, 8'h11});
    send(8'h11, 1'b0);
    exp_q.push_back({18'd1, 8'h22});
    send(8'h22, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_we", {31'd0, we}, 0);
    chk("midrst_addr", {14'd0, addr}, 0);
    chk("midrst_dout", {24'd0, dout}, 0);
    flags("midrst", 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'hAA, 1'b0);
    idle(3);
    flags("postrst", 1'b0, 1'b0, 1'b1);
    // timeout after a single data byte
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    exp_q.push_back({18'd0, 8'h77});
    send(8'h77, 1'b0);
    idle(TMO - 8);
    flags("pre_tmo", 1'b0, 1'b0, 1'b0);
    idle(16);
    flags("tmo", 1'b0, 1'b1, 1'b0);
    // rx_err with a byte in DATA: error, byte dropped
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    chk("retry_clr_err", {31'd0, err}, 0);
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    exp_q.push_back({18'd0, 8'h66});
    send(8'h66, 1'b0);
    send(8'h55, 1'b1);
    send(8'hBB, 1'b0);
    idle(3);
    flags("rxerr", 1'b0, 1'b1, 1'b0);
    run_frame(tbl[0]);
    flags("recover", 1'b1, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
